// File: rtl/datapath_mac_pkg.sv
// mac_pkg: shared widths, depths and storage types for the matrix-vector MAC datapath
package mac_pkg;
  localparam int DATA_W  = 8;
  localparam int ACC_W   = 16;
  localparam int M_DEPTH = 9;
  localparam int X_DEPTH = 3;
  localparam int M_AW    = 4;
  localparam int X_AW    = 2;
  typedef logic [DATA_W-1:0]               data_t;
  typedef logic [ACC_W-1:0]                acc_t;
  typedef logic [0:M_DEPTH-1][DATA_W-1:0]  mem_m_t;
  typedef logic [0:X_DEPTH-1][DATA_W-1:0]  mem_x_t;
endpackage

// File: rtl/datapath_mac_if.sv
// datapath_mac_if: load/read/accumulate bus between the sequencer and the MAC datapath
interface datapath_mac_if;
  import mac_pkg::*;
  data_t              data_in;
  logic               s_valid;
  logic [M_AW-1:0]    addr_M;
  logic               wr_en_M;
  logic [X_AW-1:0]    addr_X;
  logic               wr_en_X;
  logic               clr_acc;
  logic               m_ready;
  acc_t               data_out;
  mem_m_t             mem_M;
  mem_x_t             mem_X;
  modport master (
    output data_in, s_valid, addr_M, wr_en_M, addr_X, wr_en_X, clr_acc, m_ready,
    input  data_out, mem_M, mem_X
  );
  modport slave (
    input  data_in, s_valid, addr_M, wr_en_M, addr_X, wr_en_X, clr_acc, m_ready,
    output data_out, mem_M, mem_X
  );
endinterface

// File: rtl/datapath_mac_reg_file.sv
// mac_reg_file: register array with range-guarded write and zero read for out-of-range addresses
module mac_reg_file #(
  parameter int DEPTH = 9,
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          we_i,
  input  logic [AW-1:0]                 addr_i,
  input  logic [WIDTH-1:0]              wdata_i,
  output logic [WIDTH-1:0]              rdata_o,
  output logic [0:DEPTH-1][WIDTH-1:0]   mem_o
);
  localparam logic [AW:0] LIMIT = DEPTH[AW:0];
  logic [0:DEPTH-1][WIDTH-1:0] mem_q, mem_d;
  logic                        in_range;
  assign in_range = {1'b0, addr_i} < LIMIT;
  assign rdata_o  = in_range ? mem_q[addr_i] : '0;
  assign mem_o    = mem_q;
  // next image: only the addressed in-range word changes on a qualified write
  always_comb begin
    mem_d = mem_q;
    if (we_i && in_range) mem_d[addr_i] = wdata_i;
  end
  // storage register, cleared by active-low synchronous reset
  always_ff @(posedge clk) begin
    if (!reset) mem_q <= '0;
    else        mem_q <= mem_d;
  end
endmodule

// File: rtl/datapath_mac.sv
// datapath_mac: M/X byte storage with unsigned 8x8 multiply and 16-bit wrapping accumulator
module datapath_mac
  import mac_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  datapath_mac_if.slave  bus
);
  data_t m_word, x_word;
  acc_t  prod, acc_q, acc_d;
  logic  acc_en;
  mac_reg_file #(.DEPTH(M_DEPTH), .WIDTH(DATA_W), .AW(M_AW)) u_mem_m (
    .clk     (clk),
    .reset   (reset),
    .we_i    (bus.wr_en_M && bus.s_valid),
    .addr_i  (bus.addr_M),
    .wdata_i (bus.data_in),
    .rdata_o (m_word),
    .mem_o   (bus.mem_M)
  );
  mac_reg_file #(.DEPTH(X_DEPTH), .WIDTH(DATA_W), .AW(X_AW)) u_mem_x (
    .clk     (clk),
    .reset   (reset),
    .we_i    (bus.wr_en_X && bus.s_valid),
    .addr_i  (bus.addr_X),
    .wdata_i (bus.data_in),
    .rdata_o (x_word),
    .mem_o   (bus.mem_X)
  );
  assign prod         = acc_t'(m_word) * acc_t'(x_word);
  assign acc_en       = !bus.wr_en_M && !bus.wr_en_X && bus.m_ready;
  assign bus.data_out = acc_q;
  // clear beats accumulate; accumulate only while no write is in progress and downstream is ready
  always_comb acc_d = bus.clr_acc ? '0 : acc_en ? acc_q + prod : acc_q;
  // accumulator register, wraps modulo 2^16
  always_ff @(posedge clk) begin
    if (!reset) acc_q <= '0;
    else        acc_q <= acc_d;
  end
endmodule

// File: tb/tb_datapath_mac.sv
// tb_datapath_mac: directed vectors with a scoreboard queue drained by an independent monitor
module tb_datapath_mac;
  import mac_pkg::*;
  typedef struct {
    string       name;
    logic [15:0] acc;
    bit          cm;
    logic [71:0] m;
    logic [23:0] x;
  } exp_t;
  logic clk = 0;
  logic reset;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  logic [71:0] em;
  logic [23:0] ex;
  datapath_mac_if bus();
  datapath_mac dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic step(input string name, input logic r, wm, wx, sv, clr, rdy,
                      input logic [3:0] am, input logic [1:0] ax, input logic [7:0] d,
                      input logic [15:0] e_acc, input bit cm);
    exp_t e;
    @(negedge clk);
    reset = r; bus.wr_en_M = wm; bus.wr_en_X = wx; bus.s_valid = sv;
    bus.clr_acc = clr; bus.m_ready = rdy; bus.addr_M = am; bus.addr_X = ax; bus.data_in = d;
    @(posedge clk);
    e.name = name; e.acc = e_acc; e.cm = cm; e.m = em; e.x = ex;
    sb.push_back(e);
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (bus.data_out !== e.acc) begin
          errors++;
          $display("FAIL %s data_out got %0d exp %0d", e.name, bus.data_out, e.acc);
        end
        if (e.cm) begin
          checks += 2;
          if (bus.mem_M !== e.m) begin
            errors++;
            $display("FAIL %s mem_M got %h exp %h", e.name, bus.mem_M, e.m);
          end
          if (bus.mem_X !== e.x) begin
            errors++;
            $display("FAIL %s mem_X got %h exp %h", e.name, bus.mem_X, e.x);
          end
        end
      end
    end
  end
  initial begin : stim
    em = '0; ex = '0;
    step("reset", 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 8; i++) step("loadM", 1, 1, 0, 1, 0, 1, 4'(i), 0, 8'(i + 1), 0, 0);
    em = 72'h010203040506070809;
    step("loadM_last", 1, 1, 0, 1, 0, 1, 4'd8, 0, 8'd9, 0, 1);
    for (int i = 0; i < 2; i++) step("loadX", 1, 0, 1, 1, 0, 1, 0, 2'(i), 8'(i + 1), 0, 0);
    ex = 24'h010203;
    step("loadX_last", 1, 0, 1, 1, 0, 1, 0, 2'd2, 8'd3, 0, 1);
    step("clr0", 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    step("row0_a", 1, 0, 0, 0, 0, 1, 4'd0, 2'd0, 0, 16'd1, 0);
    step("row0_b", 1, 0, 0, 0, 0, 1, 4'd1, 2'd1, 0, 16'd5, 0);
    step("row0_c", 1, 0, 0, 0, 0, 1, 4'd2, 2'd2, 0, 16'd14, 1);
    step("clr1", 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    step("row1_a", 1, 0, 0, 0, 0, 1, 4'd3, 2'd0, 0, 16'd4, 0);
    step("row1_b", 1, 0, 0, 0, 0, 1, 4'd4, 2'd1, 0, 16'd14, 0);
    step("row1_c", 1, 0, 0, 0, 0, 1, 4'd5, 2'd2, 0, 16'd32, 0);
    step("clr2", 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    step("row2_a", 1, 0, 0, 0, 0, 1, 4'd6, 2'd0, 0, 16'd7, 0);
    step("stall1", 1, 0, 0, 0, 0, 0, 4'd7, 2'd1, 0, 16'd7, 0);
    step("stall2", 1, 0, 0, 0, 0, 0, 4'd7, 2'd1, 0, 16'd7, 0);
    step("row2_b", 1, 0, 0, 0, 0, 1, 4'd7, 2'd1, 0, 16'd23, 0);
    step("row2_c", 1, 0, 0, 0, 0, 1, 4'd8, 2'd2, 0, 16'd50, 0);
    step("clr_prio", 1, 0, 0, 0, 1, 1, 4'd8, 2'd2, 0, 16'd0, 0);
    step("wr_no_valid", 1, 1, 0, 0, 0, 1, 4'd0, 2'd0, 8'hAA, 0, 1);
    step("wrM_oob", 1, 1, 0, 1, 0, 1, 4'd12, 2'd0, 8'hBB, 0, 1);
    step("wrX_oob", 1, 0, 1, 1, 0, 1, 4'd0, 2'd3, 8'hCC, 0, 1);
    step("acc_00", 1, 0, 0, 0, 0, 1, 4'd0, 2'd0, 0, 16'd1, 0);
    step("rdX_oob", 1, 0, 0, 0, 0, 1, 4'd0, 2'd3, 0, 16'd1, 0);
    step("rdM_oob", 1, 0, 0, 0, 0, 1, 4'd12, 2'd0, 0, 16'd1, 1);
    step("clr3", 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    em = 72'hFF0203040506070809;
    step("wrM_ff", 1, 1, 0, 1, 0, 1, 4'd0, 0, 8'hFF, 0, 1);
    ex = 24'hFF0203;
    step("wrX_ff", 1, 0, 1, 1, 0, 1, 0, 2'd0, 8'hFF, 0, 1);
    step("wrap1", 1, 0, 0, 0, 0, 1, 4'd0, 2'd0, 0, 16'd65025, 0);
    step("wrap2", 1, 0, 0, 0, 0, 1, 4'd0, 2'd0, 0, 16'd64514, 0);
    em = 72'hFF0203040506070830;
    ex = 24'hFF0230;
    step("wr_both", 1, 1, 1, 1, 0, 1, 4'd8, 2'd2, 8'h30, 16'd64514, 1);
    step("pre_rst", 1, 0, 0, 0, 0, 1, 4'd1, 2'd1, 0, 16'd64518, 0);
    em = '0; ex = '0;
    step("rst_mid", 0, 1, 1, 1, 0, 1, 4'd1, 2'd1, 8'h77, 0, 1);
    step("post_rst", 1, 0, 0, 0, 0, 1, 4'd1, 2'd1, 0, 0, 1);
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
